uio_serial_tx: RTL and testbench

//  Byte-serial transmitter that drives the bidirectional uio pins as outputs (uio_oe set), the

---
 rtl/uio_serial_pkg.sv | 18 +
 rtl/uio_tx_bit_timer.sv | 27 ++
 rtl/uio_serial_tx.sv | 94 +++++++++
 tb/tb_uio_serial_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uio_serial_pkg.sv
// Shared types and pin map for the uio serial transmitter.
// Pin indices refer to positions within uio_out / uio_oe.
package uio_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int SDATA_BIT = 0;
  localparam int SCLK_BIT  = 1;
  localparam int FRAME_BIT = 2;
  localparam int BUSY_BIT  = 3;

  localparam logic [7:0] OE_MASK_DEFAULT = 8'h0F;

endpackage

// File: rtl/uio_tx_bit_timer.sv
// Per-bit clock divider: counts 0..CLK_DIV-1 while enabled.
// Emits the sclk-high half indicator and a wrap strobe on the last count.
module uio_tx_bit_timer #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [DIV_W-1:0] div_cnt,
  output logic             half,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_V = DIV_W'(CLK_DIV / 2);

  always_ff @(posedge clk) begin
    if (rst || clr)   div_cnt <= '0;
    else if (en)      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
  end

  assign half = (div_cnt >= HALF_V);
  assign wrap = en && (div_cnt == LAST);

endmodule

// File: rtl/uio_serial_tx.sv
// Byte-serial MSB-first transmitter on uio pins: sdata/sclk/frame/busy.
// sdata moves only at the sclk falling point so the receiver samples on sclk rise.
module uio_serial_tx
  import uio_serial_pkg::*;
#(
  parameter int         DATA_W  = 8,
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] OE_MASK = OE_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [7:0]          oe_q;
  logic [DIV_W-1:0]    div_cnt;
  logic                half, wrap;
  logic                hs, last_bit;

  assign hs       = tx_valid && tx_ready;
  assign last_bit = (bit_cnt_q == LAST_BIT);

  // Timer idles at zero in IDLE, so the first bit starts with a full period.
  uio_tx_bit_timer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != IDLE),
    .clr     (state_q == IDLE),
    .div_cnt (div_cnt),
    .half    (half),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs)              state_d = SHIFT;
      SHIFT:   if (wrap && last_bit) state_d = GAP;
      GAP:     if (wrap)            state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      oe_q      <= '0;
    end else begin
      oe_q <= OE_MASK;
      if (state_q == IDLE && hs) begin
        shift_q   <= tx_data;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT && wrap) begin
        shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    uio_out            = '0;
    uio_out[SDATA_BIT] = (state_q == SHIFT) && shift_q[DATA_W-1];
    uio_out[SCLK_BIT]  = (state_q == SHIFT) && half;
    uio_out[FRAME_BIT] = (state_q == SHIFT);
    uio_out[BUSY_BIT]  = (state_q != IDLE);
    tx_ready           = (state_q == IDLE) && !rst;
    // GAP is entered with div_cnt at zero, so this marks its first cycle only.
    tx_done            = (state_q == GAP) && (div_cnt == '0);
  end

  assign uio_oe = oe_q;

endmodule

// File: tb/tb_uio_serial_tx.sv
// Directed bench for uio_serial_tx: three instances (CLK_DIV 4, 2, 6) sharing clk/rst,
// cycle-exact pin checks on the CLK_DIV=4 instance and a pin-level receiver on all three.
module tb_uio_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       tx_done  [3];
  logic [7:0] uio_out  [3];
  logic [7:0] uio_oe   [3];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    uio_serial_tx #(
      .DATA_W  (8),
      .CLK_DIV ((i == 0) ? 4 : ((i == 1) ? 2 : 6)),
      .OE_MASK (8'h0F)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data[i]),
      .tx_valid (tx_valid[i]),
      .tx_ready (tx_ready[i]),
      .tx_done  (tx_done[i]),
      .uio_out  (uio_out[i]),
      .uio_oe   (uio_oe[i])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Receiver: shift in sdata on sclk rise inside frame, keep only full bytes.
  logic [7:0] rx_mem [3][512];
  int         rx_cnt [3]     = '{default: 0};
  int         rx_n   [3]     = '{default: 0};
  logic [7:0] rx_sh  [3]     = '{default: 8'h00};
  logic       prev_sclk [3]  = '{default: 1'b0};
  logic       prev_frame [3] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (uio_out[i][2] && uio_out[i][1] && !prev_sclk[i]) begin
        rx_sh[i] <= {rx_sh[i][6:0], uio_out[i][0]};
        rx_n[i]  <= rx_n[i] + 1;
      end
      if (prev_frame[i] && !uio_out[i][2]) begin
        if (rx_n[i] == 8) begin
          rx_mem[i][rx_cnt[i]] <= rx_sh[i];
          rx_cnt[i]            <= rx_cnt[i] + 1;
        end
        rx_n[i] <= 0;
      end
      prev_sclk[i]  <= uio_out[i][1];
      prev_frame[i] <= uio_out[i][2];
    end
  end

  // Called at a negedge with instance 0 idle; returns at the negedge ready is back.
  task automatic send_check(input logic [7:0] b, input bit hold, input bit toggle);
    logic [7:0] exp;
    int         bi;
    tx_data[0]  = b;
    tx_valid[0] = 1'b1;
    check("ready_pre", tx_ready[0], 1);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (toggle) begin
        tx_valid[0] = 1'($urandom_range(0, 1));
        tx_data[0]  = 8'($urandom);
      end else if (!hold) begin
        tx_valid[0] = 1'b0;
      end
      if (k <= 32) begin
        bi  = (k - 1) / 4;
        exp = {4'h0, 1'b1, 1'b1, ((k - 1) % 4) >= 2, b[7 - bi]};
      end else begin
        exp = 8'h08;
      end
      check($sformatf("uio b=%0h k=%0d", b, k), uio_out[0], exp);
      check($sformatf("done b=%0h k=%0d", b, k), tx_done[0], (k == 33));
      check($sformatf("ready_busy b=%0h k=%0d", b, k), tx_ready[0], 0);
    end
    @(negedge clk);
    if (!hold) tx_valid[0] = 1'b0;
    check("ready_back", tx_ready[0], 1);
    check("uio_idle", uio_out[0], 0);
    check("done_idle", tx_done[0], 0);
  endtask

  task automatic send_raw(input int i, input logic [7:0] b);
    int n = 0;
    tx_data[i]  = b;
    tx_valid[i] = 1'b1;
    while (!tx_ready[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", tx_ready[i], 1);
    @(negedge clk);
    tx_valid[i] = 1'b0;
  endtask

  logic [7:0] exp6 [3][256];
  logic [7:0] exp0 [5] = '{8'hA5, 8'hFF, 8'h00, 8'h5A, 8'hC3};
  logic [7:0] b;

  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end

    // reset held three cycles
    repeat (3) @(negedge clk);
    check("rst_uio", uio_out[0], 0);
    check("rst_oe", uio_oe[0], 0);
    check("rst_ready", tx_ready[0], 0);
    check("rst_done", tx_done[0], 0);
    rst = 1'b0;
    @(negedge clk);
    check("oe0", uio_oe[0], 8'h0F);
    check("oe1", uio_oe[1], 8'h0F);
    check("oe2", uio_oe[2], 8'h0F);
    check("ready_out_of_rst", tx_ready[0], 1);
    check("uio_out_of_rst", uio_out[0], 0);

    // single byte
    send_check(8'hA5, 1'b0, 1'b0);

    // back-to-back with valid held: second byte taken on the cycle ready returns,
    // so frame stays low for the 4-cycle gap plus that accepting cycle
    send_check(8'hFF, 1'b1, 1'b0);
    send_check(8'h00, 1'b0, 1'b0);

    // valid/data churn mid-frame
    send_check(8'h5A, 1'b0, 1'b1);

    // abort at bit 3 of 8'h3C
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    check("abort_ready_pre", tx_ready[0], 1);
    repeat (13) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
    end
    check("abort_pre_uio", uio_out[0], 8'h0D);
    rst = 1'b1;
    @(negedge clk);
    check("abort_uio", uio_out[0], 0);
    check("abort_oe", uio_oe[0], 0);
    check("abort_ready", tx_ready[0], 0);
    check("abort_done", tx_done[0], 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_abort_done", tx_done[0], 0);
      check("post_abort_uio", uio_out[0], 0);
    end
    send_check(8'hC3, 1'b0, 1'b0);

    check("rx0_cnt", rx_cnt[0], 5);
    for (int j = 0; j < 5; j++)
      check($sformatf("rx0[%0d]", j), rx_mem[0][j], exp0[j]);

    // random bytes at CLK_DIV=2 and 6
    for (int i = 1; i < 3; i++) begin
      int n;
      for (int j = 0; j < 256; j++) begin
        b = (j == 0) ? 8'h00 : ((j == 1) ? 8'hFF : 8'($urandom));
        exp6[i][j] = b;
        send_raw(i, b);
      end
      n = 0;
      while (uio_out[i][3] && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rx%0d_idle", i), uio_out[i][3], 0);
      repeat (2) @(negedge clk);
      check($sformatf("rx%0d_cnt", i), rx_cnt[i], 256);
      for (int j = 0; j < 256; j++)
        check($sformatf("rx%0d[%0d]", i, j), rx_mem[i][j], exp6[i][j]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
